// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and index sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 4;

    // Bits needed to count positions 0..n; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int IDX_W = idx_width(N_DEFAULT);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit needs a borrow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial x - y, LSB first, one bit per clock through a single full subtractor.
// Results are published only on completion; partial bits stay internal.
module serial_ripple_subtractor
    import adder_pkg::*;
#(
    parameter int n = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [n:0] x,
    input  logic [n:0] y,
    output logic [n:0] diff,
    output logic       borrow_out,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    localparam int IW = idx_width(n);
    localparam logic [IW-1:0] LAST_IDX = IW'(n);

    state_t        state_r;
    state_t        state_next_s;
    logic [n:0]    x_r;
    logic [n:0]    y_r;
    logic [n:0]    res_r;
    logic [n:0]    res_next_s;
    logic [IW-1:0] idx_r;
    logic          borrow_r;
    logic          a_s;
    logic          b_s;
    logic          d_s;
    logic          bout_s;
    logic          last_bit_s;
    logic          ovf_s;

    assign a_s = x_r[idx_r];
    assign b_s = y_r[idx_r];

    full_subtractor u_full_subtractor (
        .a    (a_s),
        .b    (b_s),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Next-state decode and merge of the current result bit into the partial word.
    always_comb begin
        state_next_s        = state_r;
        res_next_s          = res_r;
        res_next_s[idx_r]   = d_s;
        last_bit_s          = (idx_r == LAST_IDX);
        ovf_s               = (x_r[n] != y_r[n]) && (d_s != x_r[n]);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch, serial datapath and result publication on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r        <= '0;
            y_r        <= '0;
            res_r      <= '0;
            idx_r      <= '0;
            borrow_r   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x_r      <= x;
                        y_r      <= y;
                        res_r    <= '0;
                        idx_r    <= '0;
                        borrow_r <= 1'b0;
                    end else begin
                        idx_r    <= idx_r;
                    end
                end
                RUN: begin
                    res_r    <= res_next_s;
                    borrow_r <= bout_s;
                    idx_r    <= idx_r + IW'(1);
                    if (last_bit_s) begin
                        diff       <= res_next_s;
                        borrow_out <= bout_s;
                        ovf        <= ovf_s;
                    end else begin
                        diff       <= diff;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign busy = (state_r != IDLE);
    assign done = (state_r == DONE);

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed table-driven bench for serial_ripple_subtractor (n=4) plus multi-cycle corner sequences.
module tb_serial_ripple_subtractor;

    localparam int N = 4;

    typedef struct {
        logic [N:0] x;
        logic [N:0] y;
        logic [N:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [N:0] x = '0;
    logic [N:0] y = '0;
    logic [N:0] diff;
    logic       borrow_out;
    logic       ovf;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    serial_ripple_subtractor #(.n(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x          (x),
        .y          (y),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following done.
    task automatic run_op(input vec_t v, output int done_cyc);
        int lat;
        x = v.x;
        y = v.y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        lat = 0;
        done_cyc = -1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        chk("latency", lat, N + 2);
        chk("diff", {27'd0, diff}, {27'd0, v.diff});
        chk("borrow_out", {31'd0, borrow_out}, {31'd0, v.bout});
        chk("ovf", {31'd0, ovf}, {31'd0, v.ovf});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("diff_held", {27'd0, diff}, {27'd0, v.diff});
    endtask

    vec_t vecs[8];

    initial begin
        int prev_done;
        int this_done;
        int busy_cnt;
        int done_cnt;
        vec_t v;

        vecs[0] = '{5'd13, 5'd5,  5'd8,  1'b0, 1'b0};
        vecs[1] = '{5'd5,  5'd13, 5'd24, 1'b1, 1'b0};
        vecs[2] = '{5'd15, 5'd16, 5'd31, 1'b1, 1'b1};
        vecs[3] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0};
        vecs[4] = '{5'd16, 5'd1,  5'd15, 1'b0, 1'b1};
        vecs[5] = '{5'd31, 5'd31, 5'd0,  1'b0, 1'b0};
        vecs[6] = '{5'd7,  5'd25, 5'd14, 1'b1, 1'b0};
        vecs[7] = '{5'd8,  5'd24, 5'd16, 1'b1, 1'b1};

        #2;
        chk("rst_diff", {27'd0, diff}, 32'd0);
        chk("rst_flags", {29'd0, borrow_out, ovf, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vectors issued back to back: each start lands in the cycle after the previous done.
        prev_done = -1;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], this_done);
            if (prev_done >= 0) begin
                chk("b2b_spacing", this_done - prev_done, N + 3);
            end
            prev_done = this_done;
        end

        // start held high with operands changing mid-run.
        x = 5'd13;
        y = 5'd5;
        start = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                chk("hold_diff", {27'd0, diff}, 32'd8);
                chk("hold_flags", {30'd0, borrow_out, ovf}, 32'd0);
                start = 1'b0;
            end
            if (i == 1) begin
                x = 5'd5;
                y = 5'd13;
            end
        end
        start = 1'b0;
        chk("hold_busy_cycles", busy_cnt, N + 2);
        chk("hold_done_pulses", done_cnt, 1);

        // Reset asserted in the third RUN cycle.
        x = 5'd5;
        y = 5'd13;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_diff", {27'd0, diff}, 32'd0);
        chk("midrst_flags", {29'd0, borrow_out, ovf, done}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_diff_kept", {27'd0, diff}, 32'd0);
        v = '{5'd9, 5'd4, 5'd5, 1'b0, 1'b0};
        run_op(v, this_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1);
    end

endmodule

// File: doc/serial_ripple_subtractor.md
SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

Interface
REQ-001 SHALL have parameter n, default 4; operand and result width is n+1 bits (indices n..0).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port x  input  n+1  minuend, unsigned or two's complement.
REQ-006 SHALL have port y  input  n+1  subtrahend, same encoding as x.
REQ-007 SHALL have port diff  output  n+1  registered result x-y mod 2^(n+1).
REQ-008 SHALL have port borrow_out  output  1  registered final borrow; 1 iff x<y unsigned.
REQ-009 SHALL have port ovf  output  1  registered signed overflow of x-y.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL, on an edge in IDLE with start=1: latch x and y, clear internal borrow, set bit index to 0, and enter RUN.
REQ-014 SHALL, on each edge in RUN, process one bit i = index, LSB first: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin); store d into internal bit i; update borrow; increment index.
REQ-015 SHALL leave RUN for DONE on the edge that processes bit n; RUN lasts exactly n+1 cycles.
REQ-016 SHALL, on that same edge, load diff, borrow_out and ovf, and assert done.
REQ-017 SHALL, on the next edge in DONE, return to IDLE and deassert done.
REQ-018 SHALL give a latency of n+1 edges: start sampled at edge k gives done=1 in the cycle after edge k+n+1, for exactly one cycle.
REQ-019 SHALL compute ovf = (x[n] != y[n]) && (diff[n] != x[n]) from the latched operands.
REQ-020 SHALL ignore start in RUN and DONE; no queuing and no restart.
REQ-021 SHALL keep diff, borrow_out and ovf unchanged from completion until the next completion; intermediate bits never appear on diff.
REQ-022 SHALL ignore changes on x and y after the start edge.
REQ-023 SHALL allow back-to-back operations: start=1 in the cycle after done is accepted, giving a minimum period of n+3 cycles.

Reset
REQ-024 SHALL, while rst_n=0: force state IDLE, diff=0, borrow_out=0, ovf=0, done=0, busy=0, and clear internal index, borrow and operands.
REQ-025 SHALL abandon any operation in progress when reset asserts mid-RUN; no done pulse and no output update result from it.
REQ-026 SHALL resume on the first rising clk edge after rst_n deasserts, with start sampled normally.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the index width constant clog2(n+1) in shared package adder_pkg.
REQ-028 SHALL instantiate exactly one combinational sub-module full_subtractor (inputs a, b, bin; outputs d, bout) for the per-bit datapath.

Verification (n=4)
REQ-029 SHALL check: x=13, y=5, start -> after 5 RUN cycles, done pulse with diff=8, borrow_out=0, ovf=0.
REQ-030 SHALL check: x=5, y=13 -> diff=24, borrow_out=1, ovf=0.
REQ-031 SHALL check: x=15, y=16 -> diff=31, borrow_out=1, ovf=1; also x=0, y=0 -> diff=0, borrow_out=0, ovf=0.
REQ-032 SHALL check: start held high and x, y changed during RUN -> single done pulse, result from the first latched operands, busy high for 6 cycles.
REQ-033 SHALL check: rst_n low at the 3rd RUN cycle -> all outputs 0 immediately, no done; a subsequent x=9, y=4 gives diff=5.
REQ-034 SHALL check: start asserted the cycle after done -> second operation accepted, done pulses 7 cycles apart.
